// File: rtl/radiance_issue_pkg.sv
// Shared types and helpers for the warp issue arbiter and its priority picker.
package radiance_issue_pkg;

    localparam int STARVE_LIMIT_DEFAULT = 15;

    // Slot fields are sized for the widest supported configuration; unused upper bits stay zero.
    localparam int SLOT_WID_MAX = 8;
    localparam int SLOT_PC_MAX  = 64;
    localparam int SLOT_RAW_MAX = 128;

    function automatic int warp_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [SLOT_WID_MAX-1:0] wid;
        logic [SLOT_PC_MAX-1:0]  pc;
        logic [SLOT_RAW_MAX-1:0] raw;
    } issue_slot_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating priority encoder: first set request at or above start_i, wrapping to 0.
module rr_priority_picker
    import radiance_issue_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = warp_id_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_o
);

    int idx;

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = 0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = int'(start_i) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req_i[idx]) begin
                any_o     = 1'b1;
                gnt_idx_o = IW'(idx);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign gnt_o[gi] = any_o && (gnt_idx_o == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/warp_issue_arbiter.sv
// Selects one eligible warp per cycle into a single issue slot, with starvation override.
// Define ISSUE_GTO_EN for greedy-then-oldest policy; default build is round-robin.
module warp_issue_arbiter
    import radiance_issue_pkg::*;
#(
    parameter int NUM_WARPS    = 8,
    parameter int ARCH_LEN     = 32,
    parameter int INST_BITS    = 64,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_WARPS-1:0]             ibuf_valid,
    output logic [NUM_WARPS-1:0]             ibuf_ready,
    input  logic [NUM_WARPS*ARCH_LEN-1:0]    ibuf_pc,
    input  logic [NUM_WARPS*INST_BITS-1:0]   ibuf_raw,
    input  logic [NUM_WARPS-1:0]             warp_stall,
    output logic                             issue_valid,
    input  logic                             issue_ready,
    output logic [warp_id_w(NUM_WARPS)-1:0]  issue_wid,
    output logic [ARCH_LEN-1:0]              issue_pc,
    output logic [INST_BITS-1:0]             issue_raw,
    output logic [31:0]                      issue_count
);

    localparam int              WW        = warp_id_w(NUM_WARPS);
    localparam logic [3:0]      LIMIT     = 4'(STARVE_LIMIT);
    localparam logic [WW-1:0]   LAST_WARP = WW'(NUM_WARPS - 1);

    logic [NUM_WARPS-1:0]       eligible;
    logic [NUM_WARPS-1:0]       starved;
    logic [NUM_WARPS-1:0][3:0]  wait_q, wait_d;
    logic                       slot_free;
    logic                       do_grant;
    logic                       valid_q, valid_d;
    issue_slot_t                slot_q, slot_d;
    logic [31:0]                count_q, count_d;
    logic [WW-1:0]              last_grant_q, last_grant_d;

    logic [NUM_WARPS-1:0]       starve_gnt, policy_gnt, grant_oh;
    logic [WW-1:0]              starve_idx, policy_idx, grant_idx;
    logic                       starve_any, policy_any;

    assign eligible  = ibuf_valid & ~warp_stall;
    assign slot_free = ~valid_q | issue_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_wait
            assign starved[gi] = eligible[gi] && (wait_q[gi] == LIMIT);
            assign wait_d[gi]  = (!eligible[gi] || ibuf_ready[gi]) ? 4'd0 :
                                 (wait_q[gi] < LIMIT)              ? wait_q[gi] + 4'd1 :
                                                                     wait_q[gi];
        end
    endgenerate

    rr_priority_picker #(.N(NUM_WARPS)) u_starve_pick (
        .req_i     (starved),
        .start_i   ('0),
        .gnt_o     (starve_gnt),
        .gnt_idx_o (starve_idx),
        .any_o     (starve_any)
    );

`ifdef ISSUE_GTO_EN
    logic [3:0] best_cnt;

    // Stick with the last warp; otherwise take the longest waiter, lowest index on ties.
    always_comb begin
        policy_idx = '0;
        policy_any = 1'b0;
        best_cnt   = '0;
        if (eligible[last_grant_q]) begin
            policy_idx = last_grant_q;
            policy_any = 1'b1;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (eligible[w] && (!policy_any || wait_q[w] > best_cnt)) begin
                    policy_any = 1'b1;
                    best_cnt   = wait_q[w];
                    policy_idx = WW'(w);
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_gto_onehot
            assign policy_gnt[gi] = policy_any && (policy_idx == WW'(gi));
        end
    endgenerate
`else
    logic [WW-1:0] rr_start;

    assign rr_start = (last_grant_q == LAST_WARP) ? '0 : last_grant_q + WW'(1);

    rr_priority_picker #(.N(NUM_WARPS)) u_rr_pick (
        .req_i     (eligible),
        .start_i   (rr_start),
        .gnt_o     (policy_gnt),
        .gnt_idx_o (policy_idx),
        .any_o     (policy_any)
    );
`endif

    // Reset suppresses the dequeue so nothing is lost from the buffers that cycle.
    assign do_grant   = ~reset & slot_free & (starve_any | policy_any);
    assign grant_oh   = starve_any ? starve_gnt : policy_gnt;
    assign grant_idx  = starve_any ? starve_idx : policy_idx;
    assign ibuf_ready = do_grant ? grant_oh : '0;

    always_comb begin
        slot_d                    = '0;
        slot_d.wid[WW-1:0]        = grant_idx;
        slot_d.pc[ARCH_LEN-1:0]   = ibuf_pc[ARCH_LEN*grant_idx +: ARCH_LEN];
        slot_d.raw[INST_BITS-1:0] = ibuf_raw[INST_BITS*grant_idx +: INST_BITS];
    end

    assign valid_d      = do_grant ? 1'b1 : (issue_ready ? 1'b0 : valid_q);
    assign count_d      = count_q + {31'd0, valid_q & issue_ready};
    assign last_grant_d = do_grant ? grant_idx : last_grant_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q      <= 1'b0;
            slot_q       <= '0;
            count_q      <= '0;
            last_grant_q <= LAST_WARP;
            wait_q       <= '0;
        end else begin
            valid_q      <= valid_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            wait_q       <= wait_d;
            if (do_grant) begin
                slot_q <= slot_d;
            end
        end
    end

    logic unused_slot_bits;
    assign unused_slot_bits = ^slot_q;

    assign issue_valid = valid_q;
    assign issue_wid   = slot_q.wid[WW-1:0];
    assign issue_pc    = slot_q.pc[ARCH_LEN-1:0];
    assign issue_raw   = slot_q.raw[INST_BITS-1:0];
    assign issue_count = count_q;

endmodule

// File: tb/tb_warp_issue_arbiter.sv
// Randomized scoreboard bench for warp_issue_arbiter against a rule-level reference model.
module tb_warp_issue_arbiter;

    localparam int N   = 8;
    localparam int AL  = 32;
    localparam int IB  = 64;
    localparam int WW  = 3;
    localparam int LIM = 15;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      ibuf_valid, ibuf_ready, warp_stall;
    logic [N*AL-1:0]   ibuf_pc;
    logic [N*IB-1:0]   ibuf_raw;
    logic              issue_valid, issue_ready;
    logic [WW-1:0]     issue_wid;
    logic [AL-1:0]     issue_pc;
    logic [IB-1:0]     issue_raw;
    logic [31:0]       issue_count;

    always #5 clock = ~clock;

    warp_issue_arbiter #(
        .NUM_WARPS(N), .ARCH_LEN(AL), .INST_BITS(IB), .STARVE_LIMIT(LIM)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ibuf_valid  (ibuf_valid),
        .ibuf_ready  (ibuf_ready),
        .ibuf_pc     (ibuf_pc),
        .ibuf_raw    (ibuf_raw),
        .warp_stall  (warp_stall),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_wid   (issue_wid),
        .issue_pc    (issue_pc),
        .issue_raw   (issue_raw),
        .issue_count (issue_count)
    );

    typedef struct packed {
        logic [WW-1:0] wid;
        logic [AL-1:0] pc;
        logic [IB-1:0] raw;
    } exp_t;

    exp_t         sb_q[$];
    int           errors = 0;
    int           checks = 0;
    int           m_wait[N];
    int           m_last;
    bit           m_valid;
    logic [31:0]  m_count;
    logic [N-1:0] last_ready;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference grant choice, straight from the arbitration rules.
    function automatic int pick(input logic [N-1:0] elig);
        int best;
        best = -1;
        for (int w = 0; w < N; w++)
            if (elig[w] && m_wait[w] == LIM) return w;
`ifdef ISSUE_GTO_EN
        if (elig[m_last]) return m_last;
        for (int w = 0; w < N; w++)
            if (elig[w] && (best < 0 || m_wait[w] > m_wait[best])) best = w;
        return best;
`else
        for (int k = 1; k <= N; k++)
            if (elig[(m_last + k) % N]) return (m_last + k) % N;
        return best;
`endif
    endfunction

    task automatic step(input logic [N-1:0] v, input logic [N-1:0] s, input logic r, input logic rst);
        logic [N-1:0] elig, exp_ready;
        int g;
        @(negedge clock);
        ibuf_valid  = v;
        warp_stall  = s;
        issue_ready = r;
        reset       = rst;
        for (int i = 0; i < N * AL / 32; i++) ibuf_pc[32*i +: 32] = $urandom;
        for (int i = 0; i < N * IB / 32; i++) ibuf_raw[32*i +: 32] = $urandom;
        #1;
        exp_ready = '0;
        if (rst) begin
            check("ibuf_ready_in_reset", 64'(ibuf_ready), 64'(0));
            sb_q.delete();
            m_valid = 0;
            m_count = '0;
            m_last  = N - 1;
            for (int w = 0; w < N; w++) m_wait[w] = 0;
        end else begin
            check("issue_valid", 64'(issue_valid), 64'(m_valid));
            check("issue_count", 64'(issue_count), 64'(m_count));
            elig = v & ~s;
            g = (!m_valid || r) ? pick(elig) : -1;
            if (g >= 0) exp_ready[g] = 1'b1;
            check("ibuf_ready", 64'(ibuf_ready), 64'(exp_ready));
            if (g >= 0) sb_q.push_back('{wid: WW'(g), pc: ibuf_pc[AL*g +: AL], raw: ibuf_raw[IB*g +: IB]});
            for (int w = 0; w < N; w++) begin
                if (!elig[w] || g == w) m_wait[w] = 0;
                else if (m_wait[w] < LIM) m_wait[w]++;
            end
            if (m_valid && r) m_count = m_count + 32'd1;
            if (g >= 0) begin
                m_valid = 1;
                m_last  = g;
            end else if (r) begin
                m_valid = 0;
            end
        end
        last_ready = ibuf_ready;
    endtask

    // Monitor: every accepted slot is matched against the oldest expected grant.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (!reset && issue_valid && issue_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_issue", 64'(issue_wid), 64'hffff);
                end else begin
                    e = sb_q.pop_front();
                    $display("txn wid=%0d pc=%08h raw=%016h", issue_wid, issue_pc, issue_raw);
                    check("issue_wid", 64'(issue_wid), 64'(e.wid));
                    check("issue_pc",  64'(issue_pc),  64'(e.pc));
                    check("issue_raw", 64'(issue_raw), 64'(e.raw));
                end
            end
        end
    end

    initial begin
        logic [WW-1:0] h_wid;
        logic [AL-1:0] h_pc;
        logic [IB-1:0] h_raw;
        bit            seen;

        reset = 1'b1; ibuf_valid = '0; warp_stall = '0; issue_ready = 1'b0;
        ibuf_pc = '0; ibuf_raw = '0; m_last = N - 1; m_valid = 0; m_count = '0;
        for (int w = 0; w < N; w++) m_wait[w] = 0;

        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);

        // All warps valid, always ready: 0..7 then 0.
        for (int i = 0; i < 9; i++) step('1, '0, 1'b1, 1'b0);
        @(posedge clock); #1;
        check("count_after_8", 64'(issue_count), 64'd8);

        // Backpressure: slot must hold for five cycles, then drain and reload together.
        step('1, '0, 1'b0, 1'b0);
        h_wid = issue_wid; h_pc = issue_pc; h_raw = issue_raw;
        for (int i = 0; i < 5; i++) begin
            step('1, '0, 1'b0, 1'b0);
            check("hold_wid", 64'(issue_wid), 64'(h_wid));
            check("hold_pc",  64'(issue_pc),  64'(h_pc));
            check("hold_raw", 64'(issue_raw), 64'(h_raw));
        end
        step('1, '0, 1'b1, 1'b0);
        check("release_reload", 64'(last_ready != 0), 64'd1);

        // Warp 2 stalled, then released.
        for (int i = 0; i < 20; i++) step('1, 8'b0000_0100, 1'b1, 1'b0);
        seen = 0;
        for (int i = 0; i < N; i++) begin
            step('1, '0, 1'b1, 1'b0);
            if (last_ready[2]) seen = 1;
        end
        check("warp2_regrant", 64'(seen), 64'd1);

        // Long hold saturates every counter; starvation override picks lowest index.
        for (int i = 0; i < 18; i++) step('1, '0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step('1, '0, 1'b1, 1'b0);

`ifdef ISSUE_GTO_EN
        for (int i = 0; i < 40; i++) step(8'b0010_1000, '0, 1'b1, 1'b0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step(N'($urandom), N'($urandom & $urandom), ($urandom_range(0, 3) != 0), 1'b0);

        // Reset while a slot is held; first grant afterwards is warp 0.
        step('1, '0, 1'b0, 1'b0);
        step('1, '0, 1'b0, 1'b0);
        step('1, '0, 1'b0, 1'b1);
        step('1, '0, 1'b1, 1'b0);
        check("post_reset_grant0", 64'(last_ready), 64'd1);
        for (int i = 0; i < 4; i++) step('1, '0, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) step('0, '0, 1'b1, 1'b0);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
